// File: rtl/llc_snoop_responder.sv
// Snoop responder for the shared bus: looks up the LLC tag array, reports NOHIT/HIT/HITM,
// drives L1 GETLINE/INVALIDATELINE messages and writes back the new MESI state.
// Optional macro SNOOP_TRACE_EN adds simulation-only trace prints; cycle behaviour is unchanged.
// TAG_W + INDEX_W + OFFSET_W must equal 32.
module llc_snoop_responder #(
  parameter logic [3:0]  MY_ID    = 4'd0,
  parameter int unsigned TAG_W    = 11,
  parameter int unsigned INDEX_W  = 15,
  parameter int unsigned OFFSET_W = 6,
  parameter int unsigned WAY_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bus_valid,
  output logic               bus_ready,
  input  logic [2:0]         bus_op,
  input  logic [31:0]        bus_addr,
  input  logic [3:0]         bus_cache_id,
  output logic               lk_req,
  output logic [INDEX_W-1:0] lk_index,
  output logic [TAG_W-1:0]   lk_tag,
  input  logic               lk_rsp_valid,
  input  logic               lk_hit,
  input  logic [WAY_W-1:0]   lk_way,
  input  logic [1:0]         lk_mesi,
  output logic               upd_valid,
  output logic [INDEX_W-1:0] upd_index,
  output logic [WAY_W-1:0]   upd_way,
  output logic [1:0]         upd_mesi,
  output logic               l1_msg_valid,
  input  logic               l1_msg_ready,
  output logic [2:0]         l1_msg,
  output logic [31:0]        l1_addr,
  output logic               snoop_valid,
  output logic [1:0]         snoop_result,
  output logic [31:0]        snoop_addr
);

  localparam logic [2:0] OP_READ    = 3'b001;
  localparam logic [2:0] OP_WRITE   = 3'b010;
  localparam logic [2:0] OP_INVAL   = 3'b011;
  localparam logic [2:0] OP_RWIM    = 3'b100;

  localparam logic [1:0] MESI_I     = 2'd0;
  localparam logic [1:0] MESI_S     = 2'd1;
  localparam logic [1:0] MESI_M     = 2'd3;

  localparam logic [2:0] MSG_GET    = 3'b001;
  localparam logic [2:0] MSG_INV    = 3'b011;

  localparam logic [1:0] SR_NOHIT   = 2'b00;
  localparam logic [1:0] SR_HIT     = 2'b01;
  localparam logic [1:0] SR_HITM    = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WAIT_RSP,
    ST_MSG_GET,
    ST_MSG_INV,
    ST_FINISH
  } state_e;

  state_e             state;
  logic [2:0]         op_q;
  logic [31:0]        addr_q;
  logic [WAY_W-1:0]   way_q;
  logic               inv_pend_q;
  logic               upd_pend_q;
  logic [1:0]         new_mesi_q;
  logic [1:0]         result_q;

  logic [1:0]         rsp_mesi_c;
  logic               need_get_c;
  logic               need_inv_c;
  logic               need_upd_c;
  logic [1:0]         new_mesi_c;
  logic [1:0]         result_c;
  logic               accept_c;
  logic               snoopable_c;
  logic               msg_last_c;
  logic [31:0]        line_addr_c;

  // Decision table applied to the lookup response; a miss counts as state I.
  always_comb begin
    rsp_mesi_c = lk_hit ? lk_mesi : MESI_I;
    need_get_c = 1'b0;
    need_inv_c = 1'b0;
    need_upd_c = 1'b0;
    new_mesi_c = MESI_I;
    result_c   = SR_NOHIT;
    if (rsp_mesi_c != MESI_I) begin
      case (op_q)
        OP_READ: begin
          need_upd_c = 1'b1;
          new_mesi_c = MESI_S;
          need_get_c = (rsp_mesi_c == MESI_M);
          result_c   = (rsp_mesi_c == MESI_M) ? SR_HITM : SR_HIT;
        end
        OP_RWIM: begin
          need_upd_c = 1'b1;
          need_inv_c = 1'b1;
          need_get_c = (rsp_mesi_c == MESI_M);
          result_c   = (rsp_mesi_c == MESI_M) ? SR_HITM : SR_HIT;
        end
        OP_INVAL: begin
          need_upd_c = 1'b1;
          need_inv_c = 1'b1;
          result_c   = SR_HIT;
        end
        default: ;
      endcase
    end
  end

  // Handshake and message-completion helpers.
  always_comb begin
    accept_c    = (state == ST_IDLE) && bus_ready && bus_valid;
    snoopable_c = (bus_cache_id != MY_ID) && (bus_op != OP_WRITE);
    msg_last_c  = l1_msg_valid && l1_msg_ready &&
                  (((state == ST_MSG_GET) && !inv_pend_q) || (state == ST_MSG_INV));
    line_addr_c = {addr_q[31:OFFSET_W], {OFFSET_W{1'b0}}};
  end

  // Responder FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      op_q         <= '0;
      addr_q       <= '0;
      way_q        <= '0;
      inv_pend_q   <= 1'b0;
      upd_pend_q   <= 1'b0;
      new_mesi_q   <= '0;
      result_q     <= '0;
      bus_ready    <= 1'b0;
      lk_req       <= 1'b0;
      lk_index     <= '0;
      lk_tag       <= '0;
      upd_valid    <= 1'b0;
      upd_index    <= '0;
      upd_way      <= '0;
      upd_mesi     <= '0;
      l1_msg_valid <= 1'b0;
      l1_msg       <= '0;
      l1_addr      <= '0;
      snoop_valid  <= 1'b0;
      snoop_result <= '0;
      snoop_addr   <= '0;
    end else begin
      lk_req      <= 1'b0;
      upd_valid   <= 1'b0;
      snoop_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          bus_ready <= 1'b1;
          if (accept_c) begin
            op_q   <= bus_op;
            addr_q <= bus_addr;
            // Own traffic and writes are consumed without a lookup.
            if (snoopable_c) begin
              state     <= ST_LOOKUP;
              bus_ready <= 1'b0;
              lk_req    <= 1'b1;
              lk_index  <= bus_addr[OFFSET_W +: INDEX_W];
              lk_tag    <= bus_addr[31 -: TAG_W];
            end
          end
        end
        ST_LOOKUP: begin
          state <= ST_WAIT_RSP;
        end
        ST_WAIT_RSP: begin
          if (lk_rsp_valid) begin
            way_q      <= lk_way;
            inv_pend_q <= need_inv_c;
            upd_pend_q <= need_upd_c;
            new_mesi_q <= new_mesi_c;
            result_q   <= result_c;
            if (need_get_c) begin
              state        <= ST_MSG_GET;
              l1_msg_valid <= 1'b1;
              l1_msg       <= MSG_GET;
              l1_addr      <= line_addr_c;
            end else if (need_inv_c) begin
              state        <= ST_MSG_INV;
              l1_msg_valid <= 1'b1;
              l1_msg       <= MSG_INV;
              l1_addr      <= line_addr_c;
            end else begin
              state        <= ST_FINISH;
              snoop_valid  <= 1'b1;
              snoop_result <= result_c;
              snoop_addr   <= addr_q;
              upd_valid    <= need_upd_c;
              upd_index    <= lk_index;
              upd_way      <= lk_way;
              upd_mesi     <= new_mesi_c;
            end
          end
        end
        ST_MSG_GET: begin
          // GETLINE followed directly by INVALIDATELINE keeps valid high.
          if (l1_msg_ready && inv_pend_q) begin
            state  <= ST_MSG_INV;
            l1_msg <= MSG_INV;
          end
        end
        ST_MSG_INV: ;
        ST_FINISH: begin
          state     <= ST_IDLE;
          bus_ready <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
      if (msg_last_c) begin
        state        <= ST_FINISH;
        l1_msg_valid <= 1'b0;
        snoop_valid  <= 1'b1;
        snoop_result <= result_q;
        snoop_addr   <= addr_q;
        upd_valid    <= upd_pend_q;
        upd_index    <= lk_index;
        upd_way      <= way_q;
        upd_mesi     <= new_mesi_q;
      end
    end
  end

`ifdef SNOOP_TRACE_EN
  function automatic string result_name(input logic [1:0] r);
    case (r)
      SR_NOHIT: return "NOHIT";
      SR_HIT:   return "HIT";
      SR_HITM:  return "HITM";
      default:  return "UNKNOWN";
    endcase
  endfunction

  function automatic string msg_name(input logic [2:0] m);
    case (m)
      MSG_GET: return "GETLINE";
      MSG_INV: return "INVALIDATELINE";
      default: return "UNKNOWN";
    endcase
  endfunction

  // Trace of reported snoops and L1 transfers.
  always_ff @(posedge clk) begin
    if (!rst && snoop_valid)
      $display("SnoopResult: Address %h, SnoopResult: %s", snoop_addr, result_name(snoop_result));
    if (!rst && l1_msg_valid && l1_msg_ready)
      $display("L2: %s %h", msg_name(l1_msg), l1_addr);
  end
`endif

endmodule

// File: tb/tb_llc_snoop_responder.sv
// Randomized bench for llc_snoop_responder against a transaction-level reference model.
module tb_llc_snoop_responder;

  localparam logic [3:0] MY_ID = 4'd0;
  localparam logic [2:0] READ = 3'b001, WRITE = 3'b010, INVAL = 3'b011, RWIM = 3'b100;
  localparam logic [2:0] GETLINE = 3'b001, INVLINE = 3'b011;
  localparam logic [1:0] NOHIT = 2'b00, HIT = 2'b01, HITM = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_valid = 1'b0;
  logic        bus_ready;
  logic [2:0]  bus_op = 3'd0;
  logic [31:0] bus_addr = 32'd0;
  logic [3:0]  bus_cache_id = 4'd0;
  logic        lk_req;
  logic [14:0] lk_index;
  logic [10:0] lk_tag;
  logic        lk_rsp_valid = 1'b0;
  logic        lk_hit = 1'b0;
  logic [3:0]  lk_way = 4'd0;
  logic [1:0]  lk_mesi = 2'd0;
  logic        upd_valid;
  logic [14:0] upd_index;
  logic [3:0]  upd_way;
  logic [1:0]  upd_mesi;
  logic        l1_msg_valid;
  logic        l1_msg_ready = 1'b0;
  logic [2:0]  l1_msg;
  logic [31:0] l1_addr;
  logic        snoop_valid;
  logic [1:0]  snoop_result;
  logic [31:0] snoop_addr;

  int total = 0;
  int bad = 0;

  llc_snoop_responder #(.MY_ID(MY_ID)) dut (
    .clk(clk), .rst(rst),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_op(bus_op),
    .bus_addr(bus_addr), .bus_cache_id(bus_cache_id),
    .lk_req(lk_req), .lk_index(lk_index), .lk_tag(lk_tag),
    .lk_rsp_valid(lk_rsp_valid), .lk_hit(lk_hit), .lk_way(lk_way), .lk_mesi(lk_mesi),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_way(upd_way), .upd_mesi(upd_mesi),
    .l1_msg_valid(l1_msg_valid), .l1_msg_ready(l1_msg_ready), .l1_msg(l1_msg), .l1_addr(l1_addr),
    .snoop_valid(snoop_valid), .snoop_result(snoop_result), .snoop_addr(snoop_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic any_out();
    return |{bus_ready, lk_req, lk_index, lk_tag, upd_valid, upd_index, upd_way, upd_mesi,
             l1_msg_valid, l1_msg, l1_addr, snoop_valid, snoop_result, snoop_addr};
  endfunction

  // One bus operation: drive it, play lookup and L1 sides, check against the model.
  task automatic run_txn(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] id,
                         input logic hit, input logic [1:0] mesi, input logic [3:0] way,
                         input int lat, input int stall);
    logic [2:0]  msgs[$];
    logic [1:0]  eff, eres, enew;
    logic        eupd;
    logic [31:0] line, idx;
    int          cyc, st, nmsg;
    bit          done;

    // Reference model: decision table on the effective line state.
    line = addr & 32'hffff_ffc0;
    idx  = (addr >> 6) & 32'h7fff;
    eff  = hit ? mesi : 2'd0;
    eres = NOHIT;
    eupd = 1'b0;
    enew = 2'd0;
    msgs = {};
    if (eff != 2'd0) begin
      if (op == READ) begin
        eres = (eff == 2'd3) ? HITM : HIT;
        eupd = 1'b1;
        enew = 2'd1;
        if (eff == 2'd3) msgs.push_back(GETLINE);
      end else if (op == RWIM) begin
        eres = (eff == 2'd3) ? HITM : HIT;
        eupd = 1'b1;
        if (eff == 2'd3) msgs.push_back(GETLINE);
        msgs.push_back(INVLINE);
      end else if (op == INVAL) begin
        eres = HIT;
        eupd = 1'b1;
        msgs.push_back(INVLINE);
      end
    end
    nmsg = msgs.size();
    st = stall;

    chk("idle_ready", 32'(bus_ready), 1);
    bus_valid = 1'b1;
    bus_op = op;
    bus_addr = addr;
    bus_cache_id = id;
    @(negedge clk);
    bus_valid = 1'b0;
    bus_op = 3'($urandom);
    bus_addr = $urandom;
    bus_cache_id = 4'($urandom);

    if (id == MY_ID || op == WRITE) begin
      for (int q = 0; q < 4; q++) begin
        chk("ignored_quiet", 32'({bus_ready, lk_req, snoop_valid, upd_valid, l1_msg_valid}), 32'h10);
        if (q < 3) @(negedge clk);
      end
      return;
    end

    chk("lk_req", 32'(lk_req), 1);
    chk("lk_index", 32'(lk_index), idx);
    chk("lk_tag", 32'(lk_tag), addr >> 21);
    chk("busy", 32'(bus_ready), 0);
    // A response while the request is still being issued must be ignored.
    lk_rsp_valid = 1'($urandom_range(0, 1));
    lk_hit = 1'b1;
    lk_mesi = 2'd3;
    lk_way = 4'($urandom);
    for (int j = 1; j <= lat; j++) begin
      @(negedge clk);
      chk("lk_req_pulse", 32'(lk_req), 0);
      lk_rsp_valid = (j == lat);
      lk_hit  = (j == lat) ? hit : 1'($urandom);
      lk_mesi = (j == lat) ? mesi : 2'($urandom);
      lk_way  = (j == lat) ? way : 4'($urandom);
      l1_msg_ready = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    lk_rsp_valid = 1'b0;
    cyc = lat + 1;
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      if (l1_msg_valid) begin
        if (msgs.size() == 0) chk("msg_extra", 32'(l1_msg_valid), 0);
        else begin
          chk("l1_msg", 32'(l1_msg), 32'(msgs[0]));
          chk("l1_addr", l1_addr, line);
        end
      end
      if (snoop_valid) begin
        done = 1'b1;
        chk("msgs_left", 32'(msgs.size()), 0);
        chk("snoop_result", 32'(snoop_result), 32'(eres));
        chk("snoop_addr", snoop_addr, addr);
        chk("upd_valid", 32'(upd_valid), 32'(eupd));
        if (eupd) begin
          chk("upd_index", 32'(upd_index), idx);
          chk("upd_way", 32'(upd_way), 32'(way));
          chk("upd_mesi", 32'(upd_mesi), 32'(enew));
        end
        if (nmsg == 0) chk("latency", 32'(cyc), 32'(lat + 1));
      end else begin
        chk("upd_quiet", 32'(upd_valid), 0);
      end
      chk("busy_noreq", 32'({bus_ready, lk_req}), 0);
      if (st > 0 && l1_msg_valid) begin
        l1_msg_ready = 1'b0;
        st--;
      end else begin
        l1_msg_ready = 1'($urandom_range(0, 1));
      end
      if (l1_msg_valid && l1_msg_ready && msgs.size() > 0) void'(msgs.pop_front());
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("snoop_seen", 32'(done), 1);
    @(negedge clk);
    l1_msg_ready = 1'b0;
    chk("back_to_idle", 32'({bus_ready, snoop_valid, upd_valid, l1_msg_valid}), 32'h8);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'(any_out()), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(bus_ready), 1);

    run_txn(READ,  32'h1000_0040, 4'd2, 1'b1, 2'd3, 4'd3, 1, 0);
    run_txn(RWIM,  32'h2000_0087, 4'd1, 1'b1, 2'd2, 4'd5, 1, 3);
    run_txn(RWIM,  32'h0abc_de7f, 4'd7, 1'b1, 2'd3, 4'd9, 2, 1);
    run_txn(INVAL, 32'h4444_4444, 4'd3, 1'b0, 2'd3, 4'd0, 1, 0);
    run_txn(READ,  32'h5555_5555, MY_ID, 1'b1, 2'd3, 4'd1, 1, 0);
    run_txn(WRITE, 32'h6666_6600, 4'd5, 1'b1, 2'd3, 4'd1, 1, 0);
    run_txn(READ,  32'h7000_0000, 4'd4, 1'b1, 2'd1, 4'd15, 3, 0);
    run_txn(INVAL, 32'hffff_ffff, 4'd15, 1'b1, 2'd3, 4'd2, 4, 2);

    // Reset while GETLINE is pending.
    bus_valid = 1'b1;
    bus_op = READ;
    bus_addr = 32'h3000_0100;
    bus_cache_id = 4'd2;
    l1_msg_ready = 1'b0;
    @(negedge clk);
    bus_valid = 1'b0;
    @(negedge clk);
    lk_rsp_valid = 1'b1;
    lk_hit = 1'b1;
    lk_mesi = 2'd3;
    lk_way = 4'd3;
    @(negedge clk);
    lk_rsp_valid = 1'b0;
    chk("pre_rst_msg", 32'(l1_msg_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outs", 32'(any_out()), 0);
    rst = 1'b0;
    l1_msg_ready = 1'b1;
    for (int q = 0; q < 3; q++) begin
      @(negedge clk);
      chk("post_rst_quiet", 32'({bus_ready, lk_req, snoop_valid, upd_valid, l1_msg_valid}), 32'h10);
    end
    l1_msg_ready = 1'b0;
    run_txn(READ, 32'h3000_0100, 4'd2, 1'b1, 2'd3, 4'd3, 1, 0);

    for (int n = 0; n < 250; n++) begin
      logic [2:0]  op;
      logic [3:0]  id;
      int          pick;
      pick = $urandom_range(0, 3);
      op = (pick == 0) ? READ : (pick == 1) ? WRITE : (pick == 2) ? INVAL : RWIM;
      id = ($urandom_range(0, 7) == 0) ? MY_ID : 4'($urandom_range(1, 15));
      repeat ($urandom_range(0, 2)) begin
        lk_rsp_valid = 1'($urandom_range(0, 1));
        l1_msg_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      run_txn(op, $urandom, id, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              4'($urandom), $urandom_range(1, 4), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
